// File: rtl/id_exe_pipe_buffer.sv
`default_nettype none
// ============================================================================
// Module      : id_exe_pipe_buffer
// Description : ID->EXE pipeline buffer. Small FIFO with bubble insertion,
//               flush on taken branch and a saturating back-pressure counter.
// Revision    : 1.0 - initial release
// ============================================================================
module id_exe_pipe_buffer #(
    parameter int CTRL_WIDTH = 10,
    parameter int DATA_WIDTH = 148,
    parameter int DEPTH      = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_bubble,
    input  logic [CTRL_WIDTH-1:0]      in_ctrl,
    input  logic [DATA_WIDTH-1:0]      in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CTRL_WIDTH-1:0]      out_ctrl,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [15:0]                stall_cycles
);

    localparam int                 c_PTR_W     = $clog2(DEPTH);
    localparam int                 c_OCC_W     = $clog2(DEPTH+1);
    localparam logic [c_OCC_W-1:0] c_FULL      = c_OCC_W'(DEPTH);
    localparam logic [15:0]        c_STALL_MAX = 16'hFFFF;

    logic [CTRL_WIDTH-1:0] r_ctrl_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_data_mem [DEPTH];
    logic [c_PTR_W-1:0]    r_head;
    logic [c_PTR_W-1:0]    r_tail;
    logic [c_OCC_W-1:0]    r_occ;
    logic [15:0]           r_stall;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_empty;

    // Handshake status depends on registered occupancy only, never on out_ready.
    assign w_empty   = (r_occ == '0);
    assign in_ready  = (r_occ < c_FULL);
    assign out_valid = !w_empty;

    assign w_push = in_valid  && in_ready  && !flush;
    assign w_pop  = out_valid && out_ready && !flush;

    // Head is masked when empty so stale storage never leaks downstream.
    assign out_ctrl     = w_empty ? '0 : r_ctrl_mem[r_head];
    assign out_data     = w_empty ? '0 : r_data_mem[r_head];
    assign occupancy    = r_occ;
    assign stall_cycles = r_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else if (flush) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else begin
            // Power-of-two depth: pointer overflow is the modulo-DEPTH wrap.
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ctrl_mem[i] <= '0;
                r_data_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_ctrl_mem[r_tail] <= in_bubble ? '0 : in_ctrl;
            r_data_mem[r_tail] <= in_data;
        end
    end

    // Counts offered-but-refused cycles; flush deliberately leaves it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall <= '0;
        end else if (in_valid && !in_ready && (r_stall != c_STALL_MAX)) begin
            r_stall <= r_stall + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_id_exe_pipe_buffer.sv
`default_nettype none
// Testbench for id_exe_pipe_buffer: vector table on a DEPTH=2 instance,
// queue scoreboard for head contents, plus reset and DEPTH=4 wrap sequences.
module tb_id_exe_pipe_buffer;

    localparam int CW = 10;
    localparam int DW = 148;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          flush, in_valid, in_bubble, out_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          in_ready, out_valid;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
    logic [15:0]   stall_cycles;

    logic          flush4, in_valid4, in_bubble4, out_ready4;
    logic [CW-1:0] in_ctrl4;
    logic [DW-1:0] in_data4;
    logic          in_ready4, out_valid4;
    logic [CW-1:0] out_ctrl4;
    logic [DW-1:0] out_data4;
    logic [2:0]    occupancy4;
    logic [15:0]   stall_cycles4;

    id_exe_pipe_buffer #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_bubble(in_bubble), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_data(out_data), .occupancy(occupancy), .stall_cycles(stall_cycles)
    );

    id_exe_pipe_buffer #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW), .DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .flush(flush4), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_bubble(in_bubble4), .in_ctrl(in_ctrl4), .in_data(in_data4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_ctrl(out_ctrl4),
        .out_data(out_data4), .occupancy(occupancy4), .stall_cycles(stall_cycles4)
    );

    typedef struct {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } entry_t;

    typedef struct {
        logic          v;
        logic          b;
        logic          r;
        logic          f;
        logic [CW-1:0] ctrl;
        logic [7:0]    tag;
        int            exp_occ;
        int            exp_stall;
    } vec_t;

    entry_t sb[$];
    entry_t sb4[$];
    vec_t   vecs[17];
    int     n_checks = 0;
    int     n_fail   = 0;

    function automatic logic [DW-1:0] mk_data(input logic [7:0] t);
        return {t[3:0], {18{t}}};
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model decides push/pop from its own state and the held inputs, then the edge.
    task automatic step_dut();
        logic   p, q;
        entry_t e;
        p      = in_valid && (sb.size() < 2) && !flush;
        q      = (sb.size() != 0) && out_ready && !flush;
        e.ctrl = in_bubble ? '0 : in_ctrl;
        e.data = in_data;
        @(posedge clk);
        #1;
        if (flush) sb.delete();
        else begin
            if (q) sb.delete(0);
            if (p) sb.push_back(e);
        end
    endtask

    task automatic step_dut4();
        logic   p, q;
        entry_t e;
        p      = in_valid4 && (sb4.size() < 4) && !flush4;
        q      = (sb4.size() != 0) && out_ready4 && !flush4;
        e.ctrl = in_bubble4 ? '0 : in_ctrl4;
        e.data = in_data4;
        @(posedge clk);
        #1;
        if (flush4) sb4.delete();
        else begin
            if (q) sb4.delete(0);
            if (p) sb4.push_back(e);
        end
    endtask

    task automatic check_head(input string name);
        if (sb.size() != 0) begin
            chk({name, " ctrl"}, out_ctrl, sb[0].ctrl);
            chk({name, " data"}, out_data, sb[0].data);
        end else begin
            chk({name, " ctrl"}, out_ctrl, '0);
            chk({name, " data"}, out_data, '0);
        end
    endtask

    initial begin
        rst = 1'b1;
        {flush, in_valid, in_bubble, out_ready, in_ctrl, in_data} = '0;
        {flush4, in_valid4, in_bubble4, out_ready4, in_ctrl4, in_data4} = '0;

        //          v  b  r  f  ctrl     tag    occ stall
        vecs[0]  = '{1, 0, 0, 0, 10'h2A5, 8'hA1, 1, 0};
        vecs[1]  = '{1, 0, 0, 0, 10'h111, 8'hB2, 2, 0};
        vecs[2]  = '{1, 0, 0, 0, 10'h0AA, 8'hC3, 2, 1};
        vecs[3]  = '{1, 0, 0, 0, 10'h0AA, 8'hC3, 2, 2};
        vecs[4]  = '{1, 0, 0, 0, 10'h0AA, 8'hC3, 2, 3};
        vecs[5]  = '{0, 0, 1, 0, 10'h000, 8'h00, 1, 3};
        vecs[6]  = '{0, 0, 1, 0, 10'h000, 8'h00, 0, 3};
        vecs[7]  = '{0, 0, 1, 0, 10'h000, 8'h00, 0, 3};
        vecs[8]  = '{1, 1, 0, 0, 10'h3FF, 8'hD4, 1, 3};
        vecs[9]  = '{1, 0, 1, 0, 10'h155, 8'hE5, 1, 3};
        vecs[10] = '{1, 0, 0, 0, 10'h0F0, 8'hF6, 2, 3};
        vecs[11] = '{1, 0, 1, 1, 10'h123, 8'h77, 0, 4};
        vecs[12] = '{1, 0, 0, 0, 10'h0C3, 8'h88, 1, 4};
        vecs[13] = '{0, 0, 1, 0, 10'h000, 8'h00, 0, 4};
        vecs[14] = '{1, 0, 0, 0, 10'h001, 8'h99, 1, 4};
        vecs[15] = '{1, 0, 0, 0, 10'h002, 8'hAA, 2, 4};
        vecs[16] = '{1, 0, 0, 0, 10'h003, 8'hAB, 2, 5};

        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset occ",   occupancy, 0);
        chk("reset ready", in_ready, 1);
        chk("reset valid", out_valid, 0);
        chk("reset stall", stall_cycles, 0);
        check_head("reset head");
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            in_valid  = vecs[i].v;
            in_bubble = vecs[i].b;
            out_ready = vecs[i].r;
            flush     = vecs[i].f;
            in_ctrl   = vecs[i].ctrl;
            in_data   = mk_data(vecs[i].tag);
            step_dut();
            chk($sformatf("vec%0d occ", i),   occupancy, vecs[i].exp_occ);
            chk($sformatf("vec%0d ready", i), in_ready, (vecs[i].exp_occ < 2));
            chk($sformatf("vec%0d valid", i), out_valid, (vecs[i].exp_occ != 0));
            chk($sformatf("vec%0d stall", i), stall_cycles, vecs[i].exp_stall);
            check_head($sformatf("vec%0d head", i));
        end

        // Asynchronous reset between edges with two entries stored and stall=5.
        {flush, in_valid, in_bubble, out_ready} = '0;
        #3 rst = 1'b1;
        #1;
        sb.delete();
        chk("async rst occ",   occupancy, 0);
        chk("async rst ready", in_ready, 1);
        chk("async rst valid", out_valid, 0);
        chk("async rst stall", stall_cycles, 0);
        check_head("async rst head");
        #1 rst = 1'b0;

        in_valid = 1'b1;
        in_ctrl  = 10'h005;
        in_data  = mk_data(8'hBB);
        step_dut();
        in_valid = 1'b0;
        chk("post rst occ",   occupancy, 1);
        chk("post rst valid", out_valid, 1);
        check_head("post rst head");

        // DEPTH=4: fill 3, six push+pop cycles, drain 3 -> 9 pushes, pointers wrap.
        for (int i = 0; i < 12; i++) begin
            in_valid4  = (i < 9);
            out_ready4 = (i >= 3);
            in_ctrl4   = CW'(i + 1);
            in_data4   = mk_data(8'(8'h10 + i));
            step_dut4();
            chk($sformatf("d4 step%0d occ", i), occupancy4, sb4.size());
            chk($sformatf("d4 step%0d ready", i), in_ready4, (sb4.size() < 4));
            if (sb4.size() != 0) begin
                chk($sformatf("d4 step%0d ctrl", i), out_ctrl4, sb4[0].ctrl);
                chk($sformatf("d4 step%0d data", i), out_data4, sb4[0].data);
            end else begin
                chk($sformatf("d4 step%0d ctrl", i), out_ctrl4, '0);
                chk($sformatf("d4 step%0d data", i), out_data4, '0);
            end
        end
        in_valid4  = 1'b0;
        out_ready4 = 1'b0;
        chk("d4 final occ", occupancy4, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
